// File: rtl/wb_stage_pkg.sv
// Shared MIPS decode constants and field helpers for writeback, controller and hazard logic.
// Pure declarations: no latency, no flow control.
package wb_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RD,
        DST_RT,
        DST_RA
    } dst_t;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_LINK,
        SRC_MEM
    } src_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] dm;
    } wb_reg_t;

    function automatic logic [5:0] f_op(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] ir);
        return ir[5:0];
    endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// Sub-word load extraction: little-endian lane select plus sign/zero extension.
// Purely combinational, no flow control; built only when WB_LOAD_EXT_EN is defined.
module wb_stage_load_ext
    import wb_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] dm,
    input  logic [5:0]  op,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dm[7:0];
        case (addr_lo)
            2'd0:    byte_sel = dm[7:0];
            2'd1:    byte_sel = dm[15:8];
            2'd2:    byte_sel = dm[23:16];
            default: byte_sel = dm[31:24];
        endcase
        // Halfword accesses are assumed aligned, so only bit 1 picks the lane.
        half_sel = addr_lo[1] ? dm[31:16] : dm[15:0];

        ext = dm;
        case (op)
            OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ext = {24'd0, byte_sel};
            OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext = {16'd0, half_sel};
            default: ext = dm;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: registers the MEM result, decodes the destination and drives the regfile write port.
// One cycle latency, no stall/flush (bubbles via valid_M); sub-word loads need WB_LOAD_EXT_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_M,
    input  logic [31:0]      IR_M,
    input  logic [31:0]      PC_M,
    input  logic [31:0]      ALU_M,
    input  logic [31:0]      DM_M,
    output logic             RegWr,
    output logic [4:0]       RW,
    output logic [31:0]      BusW,
    output logic [31:0]      WPC,
    output logic [31:0]      IR_W,
    output logic [CNT_W-1:0] retired
);

    wb_reg_t          wb_q;
    logic [CNT_W-1:0] retired_q;
    dst_t             dst;
    src_t             src;
    logic [5:0]       op_w;
    logic [5:0]       funct_w;
    logic [31:0]      mem_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= '0;
        end else begin
            wb_q.valid <= valid_M;
            wb_q.ir    <= IR_M;
            wb_q.pc    <= PC_M;
            wb_q.alu   <= ALU_M;
            wb_q.dm    <= DM_M;
        end
    end

    // Reset wins over the increment, so the instruction in WB at reset is never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else if (wb_q.valid) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign op_w    = f_op(wb_q.ir);
    assign funct_w = f_funct(wb_q.ir);

    always_comb begin
        dst = DST_NONE;
        src = SRC_ALU;
        case (op_w)
            OP_RTYPE: begin
                case (funct_w)
                    FN_ADDU, FN_SUBU: dst = DST_RD;
                    FN_JALR: begin
                        dst = DST_RD;
                        src = SRC_LINK;
                    end
                    default: dst = DST_NONE;
                endcase
            end
            OP_ORI, OP_LUI, OP_ADDIU, OP_ADDI: dst = DST_RT;
            OP_LW: begin
                dst = DST_RT;
                src = SRC_MEM;
            end
`ifdef WB_LOAD_EXT_EN
            OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                dst = DST_RT;
                src = SRC_MEM;
            end
`endif
            OP_JAL: begin
                dst = DST_RA;
                src = SRC_LINK;
            end
            default: dst = DST_NONE;
        endcase
    end

`ifdef WB_LOAD_EXT_EN
    wb_stage_load_ext u_load_ext (
        .addr_lo (wb_q.alu[1:0]),
        .dm      (wb_q.dm),
        .op      (op_w),
        .ext     (mem_word)
    );
`else
    assign mem_word = wb_q.dm;
`endif

    always_comb begin
        RW = 5'd0;
        case (dst)
            DST_RD:  RW = f_rd(wb_q.ir);
            DST_RT:  RW = f_rt(wb_q.ir);
            DST_RA:  RW = REG_RA;
            default: RW = 5'd0;
        endcase

        BusW = wb_q.alu;
        case (src)
            SRC_LINK: BusW = wb_q.pc + LINK_OFFSET;
            SRC_MEM:  BusW = mem_word;
            default:  BusW = wb_q.alu;
        endcase
    end

    // $0 writes are dropped here so the regfile bypass never forwards a bogus $0 value.
    assign RegWr   = wb_q.valid && (dst != DST_NONE) && (RW != 5'd0);
    assign WPC     = wb_q.pc;
    assign IR_W    = wb_q.ir;
    assign retired = retired_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage MIPS pipeline: the writer side of the register-file write port. It registers the MEM-stage instruction, its PC, ALU result and raw data-memory word. From these it decodes the destination register, selects and extends the write-back value, and drives `RegWr`/`RW`/`BusW`/`WPC` into the register file for one cycle per retired instruction. It also keeps a retired-instruction counter for the bench and debug.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `valid_M`  in  1  MEM stage holds a real instruction (0 = bubble)
- `IR_M`  in  32  MEM-stage instruction word
- `PC_M`  in  32  MEM-stage PC
- `ALU_M`  in  32  ALU result / effective address
- `DM_M`  in  32  raw aligned data-memory word
- `RegWr`  out  1  register write enable
- `RW`  out  5  destination register
- `BusW`  out  32  write data
- `WPC`  out  32  PC of the writing instruction, for the write trace
- `IR_W`  out  32  WB-stage instruction, for hazard/forwarding logic
- `retired`  out  CNT_W  count of valid instructions that passed WB

## Operation
- Pipeline register (`valid_W`, `IR_W`, `PC_W`, `ALU_W`, `DM_W`) loads every posedge. There is no stall or flush input; bubbles arrive as `valid_M`=0.
- Destination decode from `IR_W`:
  - `rd`: R-type arithmetic funct addu 100001, subu 100011, and jalr 001001.
  - `rt`: ori, lui, addiu, addi, lw, lb, lbu, lh, lhu.
  - 31: jal 000011.
  - Everything else (jr, beq, sw, sb, sh, unknown) writes nothing.
- `RegWr` = `valid_W` & writes-something & (`RW` != 0). A write to $0 is suppressed here, not left to the register file.
- `BusW` source:
  - jal/jalr: `PC_W` + 8, 32-bit wrapping.
  - Loads: extended memory data.
  - Otherwise: `ALU_W`.
- Load extension, little-endian on `ALU_W[1:0]`:
  - Byte lanes: offset 0 selects bits 7:0, offset 3 selects bits 31:24.
  - Halfword uses `ALU_W[1]` only; `ALU_W[0]` is ignored.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes `DM_W` through.
- When `RegWr`=0, `RW` and `BusW` still show decoded values. Consumers must qualify them with `RegWr`.
- `retired` increments by 1 on each posedge where `valid_W`=1, whether or not a write occurs. It wraps at 2^CNT_W to 0.

## Timing
- One cycle latency: an instruction on the `_M` inputs at edge n appears on the outputs after edge n. The register file commits it at edge n+1.
- `RegWr`, `RW`, `BusW`, `WPC` are combinational from the WB pipeline register. The register file's same-cycle bypass depends on them being stable for the whole cycle.
- Reset (when `reset` is high at a posedge):
  - `valid_W`=0, `IR_W`=0, `PC_W`=0, `ALU_W`=0, `DM_W`=0, `retired`=0.
  - Hence `RegWr`=0, `RW`=0, `BusW`=0, `WPC`=0.
- Reset mid-stream: the instruction in WB at the reset edge is dropped and not counted. Reset takes priority over the counter increment.
- Back-to-back writes to the same register are issued on consecutive cycles with no gap.

## Configuration
- `WB_LOAD_EXT_EN` defined:
  - Full lb/lbu/lh/lhu extension as above.
- Not defined:
  - Only lw is a load. lb/lbu/lh/lhu opcodes decode as non-writing.
  - `BusW` for lw is `DM_W` unmodified; no extension logic is built.

## Structure
- Opcode/funct constants (R-type, addu, subu, jr, jalr, ori, lui, addiu, addi, lw, lb, lbu, lh, lhu, jal) and the field macros (`rs`, `rt`, `rd`, `op`, `funct`) go in the shared `Macro.v`. The same constants feed controller and hazard unit.
- One sub-module: `load_ext` (inputs `ALU_W[1:0]`, `DM_W`, `IR_W` opcode; output extended word). It is instantiated only under `WB_LOAD_EXT_EN`.

## Test plan
- Reset held 2 cycles, then released with `valid_M`=0 -> `RegWr`=0, `RW`=0, `BusW`=0, `WPC`=0, `retired`=0.
- addu $3,$1,$2 with `ALU_M`=0x00000005, `PC_M`=0x00003000 -> next cycle `RegWr`=1, `RW`=3, `BusW`=0x5, `WPC`=0x3000; `retired`=1 the cycle after.
- jal with `PC_M`=0x00003010 -> `RW`=31, `BusW`=0x00003018. ori writing $0 -> `RegWr`=0.
- With `WB_LOAD_EXT_EN` defined and `DM_M`=0x8000F0AB:
  - lb, offset 0 -> `BusW`=0xFFFFFFAB.
  - lbu, offset 1 -> 0x000000F0.
  - lh, offset 2 -> 0xFFFF8000.
  - lhu, offset 2 -> 0x00008000.
- Without `WB_LOAD_EXT_EN`:
  - lb -> `RegWr`=0.
  - lw with `DM_M`=0x8000F0AB -> `BusW`=0x8000F0AB.
- Reset asserted while an sw and an addu are in MEM and WB:
  - Neither instruction writes or counts.
  - `retired` reads 0 after the edge.
  - Preload `retired`=2^32−1 in a separate run: one valid instruction -> `retired`=0.
